// File: rtl/evt_gen.sv
// evt_gen: burst pulse generator emitting num_evt pulses of a given width and period.
module evt_gen #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_evt,
  input  logic [CNT_W-1:0] width,
  input  logic [CNT_W-1:0] period,
  output logic             evt,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] evt_cnt
);
  typedef enum logic [1:0] {IDLE, HIGH, LOW, FIN} state_t;
  state_t r_st, w_nxt;
  logic [CNT_W-1:0] r_num, r_weff, r_lowl, r_cnt, w_weff, w_lowl;
  logic [CNT_W:0] r_ph;
  logic w_end;
  // Low time is Peff-Weff, folded to at least one cycle when period <= Weff.
  always_comb begin
    w_weff = (width == '0) ? CNT_W'(1) : width;
    w_lowl = (period <= w_weff) ? CNT_W'(1) : period - w_weff;
    w_end  = (r_st == HIGH) ? (r_ph == {1'b0, r_weff}) : (r_ph == {1'b0, r_lowl});
  end
  always_comb begin
    w_nxt = r_st;
    case (r_st)
      IDLE: w_nxt = start ? ((num_evt == '0) ? FIN : HIGH) : IDLE;
      HIGH: w_nxt = abort ? IDLE : (w_end ? ((r_cnt < r_num) ? LOW : FIN) : HIGH);
      LOW:  w_nxt = abort ? IDLE : (w_end ? HIGH : LOW);
      FIN:  w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_st   <= IDLE;
      r_ph   <= '0;
      r_cnt  <= '0;
      r_num  <= '0;
      r_weff <= '0;
      r_lowl <= '0;
      evt    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      r_st <= w_nxt;
      r_ph <= (w_nxt != r_st) ? {{CNT_W{1'b0}}, 1'b1} : r_ph + 1'b1;
      if (r_st == IDLE && start) begin
        r_num  <= num_evt;
        r_weff <= w_weff;
        r_lowl <= w_lowl;
        r_cnt  <= {{(CNT_W-1){1'b0}}, |num_evt};
      end else if (r_st == LOW && w_nxt == HIGH)
        r_cnt <= r_cnt + 1'b1;
      evt  <= (w_nxt == HIGH);
      busy <= (w_nxt == HIGH) || (w_nxt == LOW);
      done <= (w_nxt == FIN);
    end
  end
  assign evt_cnt = r_cnt;
endmodule

// File: tb/tb_evt_gen.sv
// tb_evt_gen: random and directed stimulus checked against a timeline model of each burst.
module tb_evt_gen;
  localparam int W = 8;
  logic clk = 1'b0, rst, start, abort;
  logic [W-1:0] num_evt, width, period;
  logic evt, busy, done;
  logic [W-1:0] evt_cnt;
  int n_chk = 0, n_err = 0;
  // Model: a burst is a timeline t = 0.. after the accepting edge; done at t == T.
  bit m_act = 0;
  int t, tt, m_n, m_we, m_pe, m_cnt = 0;

  always #5 clk = ~clk;

  evt_gen #(.CNT_W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .num_evt(num_evt), .width(width), .period(period),
    .evt(evt), .busy(busy), .done(done), .evt_cnt(evt_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit s, input bit a, input int n, input int w, input int p);
    if (r) begin
      m_act = 0;
      m_cnt = 0;
    end else if (!m_act) begin
      if (s) begin
        m_n  = n;
        m_we = (w == 0) ? 1 : w;
        m_pe = (p <= m_we) ? m_we + 1 : p;
        tt   = (n == 0) ? 0 : (n - 1) * m_pe + m_we;
        t    = 0;
        m_act = 1;
        m_cnt = (n == 0) ? 0 : 1;
      end
    end else if (t == tt || abort_hit(a)) begin
      m_act = 0;
    end else begin
      t++;
      m_cnt = (t < tt) ? t / m_pe + 1 : m_n;
    end
  endtask

  function automatic bit abort_hit(input bit a);
    return a && t < tt;
  endfunction

  task automatic cycle(input bit r, input bit s, input bit a, input int n, input int w, input int p);
    rst = r; start = s; abort = a;
    num_evt = n[W-1:0]; width = w[W-1:0]; period = p[W-1:0];
    @(posedge clk);
    step(r, s, a, n, w, p);
    #1;
    check("evt",  evt,  m_act && t < tt && (t % m_pe) < m_we);
    check("busy", busy, m_act && t < tt);
    check("done", done, m_act && t == tt);
    check("evt_cnt", evt_cnt, m_cnt);
  endtask

  task automatic idle(input int k);
    repeat (k) cycle(0, 0, 0, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
  endtask

  initial begin
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 1, 1, 3, 2, 5);
    cycle(0, 1, 0, 3, 2, 5);
    idle(14);
    cycle(0, 1, 0, 2, 0, 0);
    idle(5);
    cycle(0, 1, 1, 0, 3, 3);
    idle(3);
    cycle(0, 1, 0, 4, 3, 6);
    idle(10);
    cycle(0, 0, 1, 0, 0, 0);
    idle(3);
    cycle(0, 1, 0, 3, 2, 5);
    idle(6);
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 3, 2, 5);
    idle(14);
    cycle(0, 1, 0, 3, 2, 5);
    idle(2);
    cycle(0, 1, 0, 1, 1, 1);
    idle(9);
    cycle(0, 1, 0, 2, 2, 2);
    idle(3);
    cycle(0, 1, 0, 2, 255, 255);
    idle(520);
    cycle(0, 1, 0, 255, 0, 0);
    idle(515);
    repeat (3000)
      cycle($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 29) == 0,
            $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 9));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
